// File: rtl/tage_pkg.sv
// Shared TAGE types: T0 update bundle, controller states,
// and the 2-bit saturating counter update.
package tage_pkg;

  localparam int T0_ENTRIES = 1024;
  localparam int T0_ADDR_W  = $clog2(T0_ENTRIES);
  localparam int CTR_W      = 2;

  typedef logic [CTR_W-1:0]     ctr_t;
  typedef logic [T0_ADDR_W-1:0] t0_addr_t;

  typedef struct packed {
    t0_addr_t addr;
    logic     taken;
    ctr_t     ctr;
  } t0_upd_t;

  typedef enum logic {
    INIT,
    RUN
  } t0_ctrl_state_e;

  function automatic ctr_t ctr_sat_update(
    ctr_t c,
    logic taken
  );
    if (taken)
      return (c == '1) ? c : c + ctr_t'(1);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction

endpackage

// File: rtl/tage_upd_fifo.sv
// Synchronous FIFO holding pending T0 updates,
// with occupancy count and synchronous clear.
import tage_pkg::*;

module tage_upd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = t0_upd_t,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  assign dout = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tage_t0_upd_ctrl.sv
// T0 write scheduler: init sweep, then FIFO-drained counter updates.
// Optional flush port enabled by defining TAGE_T0_FLUSH_EN.
import tage_pkg::*;

module tage_t0_upd_ctrl #(
  parameter int   NUM_ENTRIES = T0_ENTRIES,
  parameter int   DEPTH       = 4,
  parameter ctr_t INIT_CTR    = 2'b10,
  localparam int  ADDR_W      = $clog2(NUM_ENTRIES),
  localparam int  QW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  input  logic [1:0]        upd_ctr,
  input  logic              tbl_wr_block,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_waddr,
  output logic [1:0]        tbl_wdata,
  output logic              init_busy,
  output logic [QW-1:0]     q_count
`ifdef TAGE_T0_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  t0_ctrl_state_e    state;
  t0_ctrl_state_e    state_d;
  logic [ADDR_W-1:0] sweep_ptr;
  logic [ADDR_W-1:0] sweep_d;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_d;
  ctr_t              wdata_d;
  t0_upd_t           din;
  t0_upd_t           head;
  logic              push;
  logic              pop;
  logic              do_flush;
  ctr_t              base;
  ctr_t              next_ctr;

`ifdef TAGE_T0_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign din       = {upd_addr, upd_taken, upd_ctr};
  assign init_busy = (state == INIT);
  assign upd_ready = (state == RUN) && (q_count < QW'(DEPTH));
  assign push      = upd_valid && upd_ready && !do_flush;
  assign pop       = (state == RUN) && (q_count != '0)
                  && !tbl_wr_block && !do_flush;

  // Head may target the entry being written right now; use that value.
  assign base     = (tbl_we && tbl_waddr == head.addr)
                  ? tbl_wdata : head.ctr;
  assign next_ctr = ctr_sat_update(base, head.taken);

  tage_upd_fifo #(
    .DEPTH (DEPTH),
    .T     (t0_upd_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (do_flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (head),
    .count (q_count)
  );

  always_comb begin
    state_d = state;
    sweep_d = sweep_ptr;
    we_d    = 1'b0;
    waddr_d = tbl_waddr;
    wdata_d = tbl_wdata;
    if (do_flush) begin
      state_d = INIT;
      sweep_d = '0;
    end else begin
      unique case (state)
        INIT: begin
          if (!tbl_wr_block) begin
            we_d    = 1'b1;
            waddr_d = sweep_ptr;
            wdata_d = INIT_CTR;
            sweep_d = sweep_ptr + ADDR_W'(1);
            if (sweep_ptr == ADDR_W'(NUM_ENTRIES - 1))
              state_d = RUN;
          end
        end
        RUN: begin
          if (pop) begin
            we_d    = 1'b1;
            waddr_d = head.addr;
            wdata_d = next_ctr;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= INIT;
      sweep_ptr <= '0;
      tbl_we    <= 1'b0;
      tbl_waddr <= '0;
      tbl_wdata <= '0;
    end else begin
      state     <= state_d;
      sweep_ptr <= sweep_d;
      tbl_we    <= we_d;
      tbl_waddr <= waddr_d;
      tbl_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_tage_t0_upd_ctrl.sv
// Scoreboard bench for tage_t0_upd_ctrl; flush scenario
// runs only when TAGE_T0_FLUSH_EN is defined.
module tb_tage_t0_upd_ctrl;

  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid;
  logic       upd_ready;
  logic [9:0] upd_addr;
  logic       upd_taken;
  logic [1:0] upd_ctr;
  logic       tbl_wr_block;
  logic       tbl_we;
  logic [9:0] tbl_waddr;
  logic [1:0] tbl_wdata;
  logic       init_busy;
  logic [2:0] q_count;
`ifdef TAGE_T0_FLUSH_EN
  logic       flush;
`endif

  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  cyc = 0;
  wr_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  tage_t0_upd_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_addr     (upd_addr),
    .upd_taken    (upd_taken),
    .upd_ctr      (upd_ctr),
    .tbl_wr_block (tbl_wr_block),
    .tbl_we       (tbl_we),
    .tbl_waddr    (tbl_waddr),
    .tbl_wdata    (tbl_wdata),
    .init_busy    (init_busy),
    .q_count      (q_count)
`ifdef TAGE_T0_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  task automatic chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic expect_wr(int a, int d, int due);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Monitor: every issued write must match the scoreboard head.
  always @(negedge clk) begin
    if (rst && tbl_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write_addr", int'(tbl_waddr), -1);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("waddr", int'(tbl_waddr), e.addr);
        chk("wdata", int'(tbl_wdata), e.data);
        if (e.due != 0) chk("write_cycle", cyc, e.due);
      end
    end
  end

  task automatic req(int a, bit t, int c, bit acc, int d, int lat);
    upd_valid = 1'b1;
    upd_addr  = 10'(a);
    upd_taken = t;
    upd_ctr   = 2'(c);
    chk("upd_ready", int'(upd_ready), int'(acc));
    if (lat >= 0) expect_wr(a, d, cyc + lat);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    upd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_init(int lim);
    int n = 0;
    while (init_busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("init_done", int'(init_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst          = 1'b0;
    upd_valid    = 1'b0;
    upd_addr     = '0;
    upd_taken    = 1'b0;
    upd_ctr      = '0;
    tbl_wr_block = 1'b0;
`ifdef TAGE_T0_FLUSH_EN
    flush        = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", int'(tbl_we), 0);
    chk("rst_waddr", int'(tbl_waddr), 0);
    chk("rst_wdata", int'(tbl_wdata), 0);
    chk("rst_ready", int'(upd_ready), 0);
    chk("rst_busy", int'(init_busy), 1);
    chk("rst_qcount", int'(q_count), 0);

    // init sweep with a short block in the middle
    for (int i = 0; i < 1024; i++) expect_wr(i, 2, 0);
    rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("busy_mid_sweep", int'(init_busy), 1);
    chk("ready_mid_sweep", int'(upd_ready), 0);
    tbl_wr_block = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("we_blocked", int'(tbl_we), 0);
    tbl_wr_block = 1'b0;
    wait_init(1200);
    chk("ready_after_init", int'(upd_ready), 1);
    @(posedge clk);
    #1;
    chk("sweep_all_written", sb.size(), 0);
    chk("qcount_run", int'(q_count), 0);

    // basic update, latency 2
    req(10'h155, 1, 2, 1, 3, 2);
    idle(4);

    // saturation cases
    req(10'h001, 1, 3, 1, 3, 2);
    req(10'h002, 0, 0, 1, 0, 2);
    req(10'h003, 0, 1, 1, 0, 2);
    idle(5);

    // back-to-back same index uses bypass
    req(10'h020, 1, 1, 1, 2, 2);
    req(10'h020, 1, 1, 1, 3, 2);
    idle(5);

    // fill while blocked, then drain in order
    tbl_wr_block = 1'b1;
    for (int i = 0; i < 4; i++) req(10'h100 + i, 1, 1, 1, 0, -1);
    req(10'h104, 1, 1, 0, 0, -1);
    upd_valid = 1'b0;
    chk("q_full", int'(q_count), 4);
    chk("ready_full", int'(upd_ready), 0);
    chk("we_while_blocked", int'(tbl_we), 0);
    r = cyc;
    tbl_wr_block = 1'b0;
    for (int i = 0; i < 4; i++) expect_wr(10'h100 + i, 2, r + 1 + i);
    idle(6);
    chk("q_drained", int'(q_count), 0);
    chk("drain_written", sb.size(), 0);

`ifdef TAGE_T0_FLUSH_EN
    tbl_wr_block = 1'b1;
    for (int i = 0; i < 3; i++) req(10'h200 + i, 1, 0, 1, 0, -1);
    chk("q_before_flush", int'(q_count), 3);
    upd_valid = 1'b1;
    upd_addr  = 10'h3ff;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    upd_valid = 1'b0;
    chk("flush_qcount", int'(q_count), 0);
    chk("flush_busy", int'(init_busy), 1);
    chk("flush_ready", int'(upd_ready), 0);
    chk("flush_we", int'(tbl_we), 0);
    for (int i = 0; i < 1024; i++) expect_wr(i, 2, 0);
    tbl_wr_block = 1'b0;
    idle(20);
    chk("resweep_busy", int'(init_busy), 1);
    rst = 1'b0;
    #1;
    chk("arst_we", int'(tbl_we), 0);
    chk("arst_waddr", int'(tbl_waddr), 0);
    chk("arst_wdata", int'(tbl_wdata), 0);
    chk("arst_busy", int'(init_busy), 1);
    chk("arst_ready", int'(upd_ready), 0);
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
`endif

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
